// File: rtl/morty_hazard_pkg.sv
// Shared types and encodings for the Morty hazard/stall controller.
package morty_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_TRAP    = 2'd3
    } hz_state_e;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_XCALL   = 1'b1;

endpackage

// File: rtl/morty_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: per-stage flags in, stall/trap controls out.
interface morty_hazard_ctrl_if #(
    parameter int NSTAGE = 3,
    parameter int CNT_W  = 16
);
    logic [NSTAGE-1:0] illegal_i;
    logic [NSTAGE-1:0] xcall_break_i;
    logic [NSTAGE-1:0] csr_op_i;
    logic [NSTAGE-1:0] ld_op_i;
    logic [NSTAGE-1:0] dep_i;
    logic              mem_ready_i;
    logic              trap_ack_i;
    logic              stall_o;
    logic              bubble_o;
    logic              enable_fwd_o;
    logic              trap_req_o;
    logic              trap_cause_o;
    logic              flush_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output illegal_i, xcall_break_i, csr_op_i, ld_op_i, dep_i, mem_ready_i, trap_ack_i,
        input  stall_o, bubble_o, enable_fwd_o, trap_req_o, trap_cause_o, flush_o,
               state_o, stall_cnt_o
    );

    modport slave (
        input  illegal_i, xcall_break_i, csr_op_i, ld_op_i, dep_i, mem_ready_i, trap_ack_i,
        output stall_o, bubble_o, enable_fwd_o, trap_req_o, trap_cause_o, flush_o,
               state_o, stall_cnt_o
    );

endinterface

// File: rtl/morty_sat_counter.sv
// Saturating up-counter with asynchronous reset; sticks at all-ones.
module morty_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morty_hazard_ctrl.sv
// Sequential hazard controller beside ID: load-use waits, CSR RAW stalls and exception drain/trap.
module morty_hazard_ctrl
    import morty_hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int LD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    morty_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] S_RUN     = 2'(ST_RUN);
    localparam logic [1:0] S_LD_WAIT = 2'(ST_LD_WAIT);
    localparam logic [1:0] S_DRAIN   = 2'(ST_DRAIN);
    localparam logic [1:0] S_TRAP    = 2'(ST_TRAP);

    localparam int               LDW     = (LD_LAT > 1) ? $clog2(LD_LAT) : 1;
    localparam logic [LDW-1:0]   LD_INIT = (LD_LAT > 0) ? LDW'(LD_LAT - 1) : '0;
    // Stage 0 is ID itself, so its dependency bit never creates a hazard.
    localparam logic [NSTAGE-1:0] OLDER  = {{(NSTAGE-1){1'b1}}, 1'b0};

    logic [1:0]        state_q, state_d;
    logic [LDW-1:0]    ld_cnt_q, ld_cnt_d;
    logic              cause_q, cause_d;
    logic [NSTAGE-1:0] exc;
    logic              exc_any, ld_hz, csr_hz, hz_any, in_run;
    logic              stall_raw, bubble_raw, fwd_raw;

    assign exc     = hz.illegal_i | hz.xcall_break_i;
    assign exc_any = |exc;
    assign ld_hz   = |(hz.dep_i & hz.ld_op_i & OLDER);
    assign csr_hz  = |(hz.dep_i & hz.csr_op_i & OLDER);
    assign hz_any  = exc_any | ld_hz | csr_hz;
    assign in_run  = (state_q == S_RUN);

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        cause_d  = cause_q;
        case (state_q)
            S_RUN: begin
                if (exc_any) begin
                    state_d = S_DRAIN;
                end else if (ld_hz && (LD_LAT > 0)) begin
                    state_d  = S_LD_WAIT;
                    ld_cnt_d = LD_INIT;
                end
            end
            S_LD_WAIT: begin
                if (exc_any)
                    state_d = S_DRAIN;
                else if (ld_cnt_q == '0) begin
                    if (hz.mem_ready_i)
                        state_d = S_RUN;
                end else
                    ld_cnt_d = ld_cnt_q - LDW'(1);
            end
            S_DRAIN: begin
                // The oldest exception reaches retire first; illegal outranks xcall there.
                if (exc[NSTAGE-1]) begin
                    state_d = S_TRAP;
                    cause_d = hz.illegal_i[NSTAGE-1] ? CAUSE_ILLEGAL :
                              (hz.xcall_break_i[NSTAGE-1] ? CAUSE_XCALL : CAUSE_ILLEGAL);
                end
            end
            default: begin
                if (hz.trap_ack_i)
                    state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_RUN;
            ld_cnt_q <= '0;
            cause_q  <= CAUSE_ILLEGAL;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            cause_q  <= cause_d;
        end
    end

    assign stall_raw  = in_run ? hz_any : 1'b1;
    assign bubble_raw = in_run ? hz_any : (state_q != S_TRAP);
    assign fwd_raw    = in_run & ~hz_any;

    // Input-dependent outputs are forced to their idle values while reset is held.
    assign hz.stall_o      = stall_raw & ~rst_i;
    assign hz.bubble_o     = bubble_raw & ~rst_i;
    assign hz.enable_fwd_o = fwd_raw | rst_i;
    assign hz.trap_req_o   = (state_q == S_TRAP);
    assign hz.trap_cause_o = cause_q;
    assign hz.flush_o      = (state_q == S_TRAP) & hz.trap_ack_i;
    assign hz.state_o      = state_q;

    morty_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hz.stall_o),
        .cnt_o (hz.stall_cnt_o)
    );

endmodule

// File: tb/tb_morty_hazard_ctrl.sv
// Randomised and directed bench for morty_hazard_ctrl against a rule-level reference model.
module tb_morty_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] ill = '0, xc = '0, cs = '0, ld = '0, dp = '0;
    logic       mr = 1'b0, ak = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    morty_hazard_ctrl_if #(.NSTAGE(3), .CNT_W(16)) ifa ();
    morty_hazard_ctrl_if #(.NSTAGE(3), .CNT_W(4))  ifb ();

    assign ifa.illegal_i = ill;  assign ifb.illegal_i = ill;
    assign ifa.xcall_break_i = xc; assign ifb.xcall_break_i = xc;
    assign ifa.csr_op_i = cs;    assign ifb.csr_op_i = cs;
    assign ifa.ld_op_i = ld;     assign ifb.ld_op_i = ld;
    assign ifa.dep_i = dp;       assign ifb.dep_i = dp;
    assign ifa.mem_ready_i = mr; assign ifb.mem_ready_i = mr;
    assign ifa.trap_ack_i = ak;  assign ifb.trap_ack_i = ak;

    morty_hazard_ctrl #(.NSTAGE(3), .LD_LAT(2), .CNT_W(16)) dut_a (
        .clk_i (clk), .rst_i (rst), .hz (ifa)
    );
    morty_hazard_ctrl #(.NSTAGE(3), .LD_LAT(0), .CNT_W(4)) dut_b (
        .clk_i (clk), .rst_i (rst), .hz (ifb)
    );

    // Reference model: one entry per DUT instance (0 = LD_LAT 2 / 16-bit count, 1 = LD_LAT 0 / 4-bit count).
    localparam int M_RUN = 0, M_LDW = 1, M_DRAIN = 2, M_TRAP = 3;
    int lat  [2] = '{2, 0};
    int cmax [2] = '{65535, 15};
    int m_mode [2];
    int m_wait [2];
    int m_cause[2];
    int m_cnt  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit exc_any();
        return |(ill | xc);
    endfunction
    function automatic bit ld_hazard();
        return (dp[1] & ld[1]) | (dp[2] & ld[2]);
    endfunction
    function automatic bit csr_hazard();
        return (dp[1] & cs[1]) | (dp[2] & cs[2]);
    endfunction

    function automatic bit exp_stall(int i);
        if (m_mode[i] == M_RUN) return exc_any() | ld_hazard() | csr_hazard();
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_RUN; m_wait[i] = 0; m_cause[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic [7:0]  got;
            logic [31:0] cnt;
            bit hz, st, bb, fw, rq, fl;
            string p;
            p  = (i == 0) ? "A." : "B.";
            hz = exc_any() | ld_hazard() | csr_hazard();
            st = exp_stall(i);
            bb = (m_mode[i] == M_RUN) ? hz : (m_mode[i] != M_TRAP);
            fw = (m_mode[i] == M_RUN) && !hz;
            rq = (m_mode[i] == M_TRAP);
            fl = rq && ak;
            if (i == 0) begin
                got = {ifa.stall_o, ifa.bubble_o, ifa.enable_fwd_o, ifa.trap_req_o,
                       ifa.flush_o, ifa.trap_cause_o, ifa.state_o};
                cnt = 32'(ifa.stall_cnt_o);
            end else begin
                got = {ifb.stall_o, ifb.bubble_o, ifb.enable_fwd_o, ifb.trap_req_o,
                       ifb.flush_o, ifb.trap_cause_o, ifb.state_o};
                cnt = 32'(ifb.stall_cnt_o);
            end
            chk({p, "stall"},  32'(got[7]), 32'(st));
            chk({p, "bubble"}, 32'(got[6]), 32'(bb));
            chk({p, "fwd"},    32'(got[5]), 32'(fw));
            chk({p, "req"},    32'(got[4]), 32'(rq));
            chk({p, "flush"},  32'(got[3]), 32'(fl));
            chk({p, "state"},  32'(got[1:0]), 32'(m_mode[i]));
            chk({p, "cnt"},    cnt, 32'(m_cnt[i]));
            if (rq) chk({p, "cause"}, 32'(got[2]), 32'(m_cause[i]));
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 2; i++) begin
            if (exp_stall(i) && m_cnt[i] < cmax[i]) m_cnt[i]++;
            case (m_mode[i])
                M_RUN: begin
                    if (exc_any()) m_mode[i] = M_DRAIN;
                    else if (ld_hazard() && lat[i] > 0) begin
                        m_mode[i] = M_LDW; m_wait[i] = lat[i] - 1;
                    end
                end
                M_LDW: begin
                    if (exc_any()) m_mode[i] = M_DRAIN;
                    else if (m_wait[i] == 0) begin
                        if (mr) m_mode[i] = M_RUN;
                    end else m_wait[i]--;
                end
                M_DRAIN: begin
                    if (ill[2] | xc[2]) begin
                        m_mode[i]  = M_TRAP;
                        m_cause[i] = (ill[2] == 1'b0 && xc[2] == 1'b1) ? 1 : 0;
                    end
                end
                default: if (ak) m_mode[i] = M_RUN;
            endcase
        end
    endtask

    task automatic step(input logic [2:0] il_v, xc_v, cs_v, ld_v, dp_v, input logic mr_v, ak_v);
        @(negedge clk);
        ill = il_v; xc = xc_v; cs = cs_v; ld = ld_v; dp = dp_v; mr = mr_v; ak = ak_v;
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
    endtask

    task automatic idle(input logic mr_v);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, mr_v, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ill = '0; xc = '0; cs = '0; ld = '0; dp = '0; mr = 1'b0; ak = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();
        #1;
        chk("rst.state", 32'(ifa.state_o), 32'd0);
        chk("rst.cnt",   32'(ifa.stall_cnt_o), 32'd0);
        chk("rst.fwd",   32'(ifa.enable_fwd_o), 32'd1);
        chk("rst.req",   32'(ifa.trap_req_o), 32'd0);

        // Load-use with memory ready: detect + two wait cycles.
        step(3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        chk("ld.cnt3", 32'(ifa.stall_cnt_o), 32'd3);

        // Load-use with memory late.
        do_reset();
        step(3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) idle(1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);

        // CSR read-after-write for two cycles, plus a plain dependency that must not stall.
        do_reset();
        step(3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 1'b1, 1'b0);
        step(3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 1'b1, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 1'b1, 1'b0);
        chk("csr.cnt2", 32'(ifa.stall_cnt_o), 32'd2);

        // Illegal instruction walks to retire, trap acked after three cycles.
        do_reset();
        step(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        idle(1'b1);

        // Exception preempts a load wait; then both flags at retire.
        do_reset();
        step(3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 1'b0, 1'b0);
        step(3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
        step(3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b100, 3'b100, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);
        idle(1'b1);

        // Asynchronous reset while a trap is pending.
        do_reset();
        step(3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        step(3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
        idle(1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.req", 32'(ifa.trap_req_o), 32'd0);
        chk("arst.fwd", 32'(ifa.enable_fwd_o), 32'd1);
        chk("arst.cnt", 32'(ifa.stall_cnt_o), 32'd0);
        chk("arst.stall", 32'(ifa.stall_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Twenty stall cycles saturate the 4-bit counter.
        for (int c = 0; c < 20; c++) step(3'b000, 3'b000, 3'b010, 3'b000, 3'b010, 1'b1, 1'b0);
        idle(1'b1);
        chk("sat.B", 32'(ifb.stall_cnt_o), 32'd15);
        chk("sat.A", 32'(ifa.stall_cnt_o), 32'd20);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [2:0] r_il, r_xc;
            if (n % 200 == 0) do_reset();
            for (int b = 0; b < 3; b++) begin
                r_il[b] = ($urandom_range(13) == 0);
                r_xc[b] = ($urandom_range(13) == 0);
            end
            step(r_il, r_xc, 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom_range(1)), ($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/morty_hazard_ctrl.md
Name: morty_hazard_ctrl

Overview:
Parametrised sequential hazard/stall controller for the Morty pipeline. It replaces purely combinational stall requests with an FSM that handles:
- multi-cycle load-use waits gated by memory readiness;
- CSR read-after-write stalls;
- exception draining, with a trap request/acknowledge handshake to the CSR/trap logic.

It sits beside ID and drives the IF/ID freeze, the EX bubble, forwarding enable and the pipeline flush.

Parameters:
NSTAGE, 3, number of tracked stages; index 0 = ID, index NSTAGE-1 = retire stage (MEM); legal range 2..8
LD_LAT, 2, extra cycles load data is unavailable after detection; 0 means purely combinational load stall
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
illegal_i  in  NSTAGE  per-stage illegal-instruction flag
xcall_break_i  in  NSTAGE  per-stage ECALL/EBREAK flag
csr_op_i  in  NSTAGE  per-stage CSR-write op flag
ld_op_i  in  NSTAGE  per-stage load op flag
dep_i  in  NSTAGE  bit k: an ID source register matches stage k destination; bit 0 ignored
mem_ready_i  in  1  load data valid from data memory
trap_ack_i  in  1  trap logic accepted trap request
stall_o  out  1  freeze PC and IF/ID
bubble_o  out  1  insert NOP into ID/EX
enable_fwd_o  out  1  forwarding allowed
trap_req_o  out  1  trap request, held until acked
trap_cause_o  out  1  0 = illegal, 1 = xcall/break; valid while trap_req_o
flush_o  out  1  one-cycle pipeline flush
state_o  out  2  FSM state, for debug
stall_cnt_o  out  CNT_W  saturating count of stall_o cycles

Behaviour:
- Derived signals:
  - exc[k] = illegal_i[k] | xcall_break_i[k].
  - ld_hz = OR over k>=1 of dep_i[k] & ld_op_i[k].
  - csr_hz = OR over k>=1 of dep_i[k] & csr_op_i[k].
- States, encoded 2 bits: RUN=0, LD_WAIT=1, DRAIN=2, TRAP=3.
- Reset (asynchronous, any state):
  - state=RUN, ld counter=0, stall_cnt_o=0.
  - stall_o=0, bubble_o=0, trap_req_o=0, trap_cause_o=0, flush_o=0, enable_fwd_o=1.
- RUN:
  - Any exc bit set: go to DRAIN. stall_o=1 and bubble_o=1 combinationally in this cycle.
  - Else ld_hz:
    - stall_o=1, bubble_o=1.
    - If LD_LAT>0: go to LD_WAIT with counter=LD_LAT-1.
    - If LD_LAT=0: stay in RUN; stall holds while ld_hz.
  - Else csr_hz: stall_o=1, bubble_o=1, stay in RUN; no counter.
- LD_WAIT:
  - stall_o=1, bubble_o=1.
  - Counter decrements each cycle, floor 0.
  - Exit to RUN when counter==0 and mem_ready_i=1.
  - If counter==0 and mem_ready_i=0: hold indefinitely.
  - Any exc bit set: go to DRAIN immediately; exception preempts the wait.
- DRAIN:
  - stall_o=1, bubble_o=1.
  - Wait until exc[NSTAGE-1]=1, then go to TRAP.
  - On that transition, latch trap_cause_o = xcall_break_i[NSTAGE-1] & ~illegal_i[NSTAGE-1]; illegal wins when both are set.
  - The oldest exception always reaches the retire stage first, so no stage index is stored.
- TRAP:
  - trap_req_o=1, stall_o=1, bubble_o=0.
  - On trap_ack_i=1: flush_o=1 in the same cycle (combinational on ack), go to RUN.
  - trap_req_o drops the cycle after ack.
- enable_fwd_o:
  - = ~(ld_hz | csr_hz) when state==RUN and no exc bit is set.
  - = 0 in LD_WAIT, DRAIN and TRAP.
- Other outputs:
  - flush_o is never asserted outside TRAP.
  - state_o is the registered state.
- stall_cnt_o increments on each clock edge where stall_o=1; saturates at all-ones, no wrap.
- Simultaneous events:
  - exc beats ld_hz beats csr_hz.
  - trap_ack_i outside TRAP is ignored.
  - A dep_i bit with neither ld nor csr op produces no stall; forwarding covers it.
- Reset asserted mid-LD_WAIT or mid-TRAP: all outputs return to reset values asynchronously; a pending trap is discarded.

Decomposition:
- Shared package morty_hazard_pkg holds:
  - the state enum (RUN/LD_WAIT/DRAIN/TRAP, 2-bit);
  - cause encodings CAUSE_ILLEGAL=0, CAUSE_XCALL=1.
- One sub-module: morty_sat_counter (parametrised width, inc, async reset), used for stall_cnt_o.
- The LD counter stays inline.

Test Plan:
1. NSTAGE=3, LD_LAT=2, ld_op_i=3'b010, dep_i=3'b010, mem_ready_i=1 -> stall_o high 3 cycles (detect + 2 wait), state_o 0→1→1→0, stall_cnt_o=3, enable_fwd_o low throughout.
2. Same as 1 but mem_ready_i=0 until cycle 6 -> stall_o held through cycle 6, exits to RUN the next cycle.
3. csr_op_i=3'b100, dep_i=3'b100 for 2 cycles -> stall_o and bubble_o high exactly 2 cycles, state_o stays 0.
4. illegal_i=3'b001 shifting to 3'b010 then 3'b100 -> DRAIN for 2 cycles, then TRAP with trap_cause_o=0; trap_ack_i after 3 cycles -> flush_o one-cycle pulse, state_o=0.
5. Inside LD_WAIT, xcall_break_i=3'b100 -> immediate DRAIN→TRAP, trap_cause_o=1; illegal_i and xcall_break_i both set at stage 2 -> trap_cause_o=0.
6. rst_i asserted mid-TRAP -> trap_req_o=0, enable_fwd_o=1 and stall_cnt_o=0 without waiting for a clock edge; with CNT_W=4, 20 stall cycles -> stall_cnt_o=15.
